ins_fetch: RTL and testbench
============================

Name: ins_fetch

Overview:
Instruction fetch stage that sits directly upstream of the instruction decoder (ins_dec) in the 4-bit CPU.
- Holds the program counter (PC) and reads 9-bit instruction words from instruction memory over a req/ack handshake.
- Resolves jump and halt words locally; these never reach the decoder.
- Presents each remaining instruction on INS with a valid/stall handshake to the downstream stage.

Parameters:
PC_W, 8, PC and instruction-memory address width; jump target is INS[PC_W-1:0], so PC_W must be <= 8
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = fetch permitted, 0 = finish the current fetch/issue, then go to IDLE
imem_addr  output  PC_W  instruction memory address
imem_req  output  1  memory request; held until ack
imem_ack  input  1  memory acknowledge; imem_data valid in the same cycle
imem_data  input  9  instruction word from memory
INS  output  9  instruction to the decoder
ins_valid  output  1  INS holds a newly issued instruction
stall  input  1  downstream not ready; hold the current issue
pc  output  PC_W  current PC
halted  output  1  fetch halted by a jump-to-self word

Behaviour:
Reset values (async on rst_n low, regardless of state):
- state=IDLE, pc=RESET_PC, INS=NOP (9'b011000000; decodes to write_en=0), ins_valid=0, imem_req=0, halted=0.

Encoding:
- imem_data[8]=1 is a JUMP; target = imem_data[PC_W-1:0].
- A JUMP whose target equals the current pc is a HALT.
- All other words are issued to the decoder unmodified.

FSM states: IDLE, REQ, ISSUE, HALT.
- IDLE: outputs idle. run=1 -> REQ.
- REQ: imem_req=1, imem_addr=pc; both held stable until imem_ack. On the ack edge:
  - normal word: INS<=imem_data, ins_valid<=1, pc<=pc+1 (wraps modulo 2^PC_W), -> ISSUE
  - JUMP, target != pc: pc<=target, INS unchanged, ins_valid stays 0, -> REQ (run=1) or IDLE (run=0)
  - HALT: halted<=1, pc unchanged, -> HALT
- ISSUE: ins_valid=1, INS stable.
  - stall=1: remain in ISSUE.
  - stall=0: ins_valid<=0 next edge, -> REQ if run=1, else IDLE.
  - INS keeps its value until the next issue.
- HALT: imem_req=0, ins_valid=0, halted=1; left only by reset.

Timing and boundaries:
- Latency: with zero-wait memory (ack in the first REQ cycle), ins_valid rises 1 cycle after REQ is entered. Throughput is 1 instruction per 2 cycles.
- run is sampled only in IDLE and on exit from ISSUE or JUMP. Deasserting run mid-REQ does not drop imem_req.
- stall is ignored outside ISSUE.
- PC wrap: from pc=2^PC_W-1, a normal fetch gives pc=0 with no flag.
- Reset asserted mid-REQ drops imem_req asynchronously. A late imem_ack after reset is ignored because the FSM is in IDLE.
- A JUMP never produces ins_valid. Consecutive jumps each cost one REQ.

Optional Feature:
Macro: INS_FETCH_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - The REQ->ISSUE path requires a step pulse first, detected by a rising edge of a registered copy of step. The FSM waits in IDLE for that edge even when run=1.
  - Exactly one instruction is issued per step edge. Jumps are resolved inside the same step.
  - Extra step edges while busy are dropped.
- Not defined: no step port; behaviour exactly as above.

Decomposition:
- Package ins_fetch_pkg: state enum (IDLE/REQ/ISSUE/HALT), NOP constant 9'b011000000, JUMP_BIT=8, INS_W=9.
- One sub-module: pc_counter. Holds the PC register with async reset to RESET_PC, load (jump target), increment with wrap, and hold. The FSM stays in ins_fetch.

Test Plan:
- Reset then run=1, memory returns 9'h001 at addr 0 with zero wait -> imem_req high 1 cycle at addr 0; INS=9'h001, ins_valid=1 next cycle; pc=1.
- Word at addr 1 = 9'h105 (jump to 5) -> ins_valid stays 0, next imem_addr=5, INS still 9'h001.
- stall=1 for 3 cycles during ISSUE of 9'h0C3 -> ins_valid and INS=9'h0C3 held 3 cycles, no imem_req; issue completes after stall=0.
- pc=8'hFF fetching 9'h000 -> pc wraps to 0, next imem_addr=0.
- Word at addr 7 = 9'h107 -> halted=1, no further imem_req; rst_n pulse -> halted=0, pc=RESET_PC.
- ack delayed 4 cycles with rst_n pulsed low in cycle 2 -> imem_req drops immediately, state IDLE, late ack ignored, INS=NOP.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: shared types and constants for the instruction fetch stage
package ins_fetch_pkg;
   typedef enum logic [1:0] {IDLE, REQ, ISSUE, HALT} state_t;
   localparam int INS_W = 9;
   localparam int JUMP_BIT = 8;
   localparam logic [INS_W-1:0] NOP = 9'b011000000;
endpackage

// File: rtl/ins_fetch_pc_counter.sv
// pc_counter: program counter with load, wrapping increment and hold
module pc_counter #(
   parameter int PC_W = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            inc,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);
   // load has priority; increment wraps naturally at 2^PC_W
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pc <= RESET_PC;
      else if (load) pc <= target;
      else if (inc) pc <= pc + 1'b1;
endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: PC + imem req/ack fetch, local jump/halt resolution, valid/stall issue (option: INS_FETCH_SINGLE_STEP_EN)
module ins_fetch
   import ins_fetch_pkg::*;
#(
   parameter int PC_W = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
`ifdef INS_FETCH_SINGLE_STEP_EN
   input  logic             step,
`endif
   output logic [PC_W-1:0]  imem_addr,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [INS_W-1:0] imem_data,
   output logic [INS_W-1:0] INS,
   output logic             ins_valid,
   input  logic             stall,
   output logic [PC_W-1:0]  pc,
   output logic             halted
);
   state_t state, next;
   logic take, is_jump, is_halt, go;
   state_t issue_exit;
   assign take    = state == REQ && imem_ack;
   assign is_jump = imem_data[JUMP_BIT];
   assign is_halt = is_jump && imem_data[PC_W-1:0] == pc;
`ifdef INS_FETCH_SINGLE_STEP_EN
   logic step_q, step_qq;
   // registered copy of step; a rising edge arms one fetch from IDLE
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {step_q, step_qq} <= 2'b00;
      else {step_q, step_qq} <= {step, step_q};
   assign go = run && step_q && !step_qq;
   assign issue_exit = IDLE;
`else
   assign go = run;
   assign issue_exit = run ? REQ : IDLE;
`endif
   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= next;
   // next-state: jumps loop back to REQ, halts park forever
   always_comb begin
      next = state;
      case (state)
         IDLE:  next = go ? REQ : IDLE;
         REQ:   next = !imem_ack ? REQ : !is_jump ? ISSUE : is_halt ? HALT : run ? REQ : IDLE;
         ISSUE: next = stall ? ISSUE : issue_exit;
         HALT:  next = HALT;
         default: next = IDLE;
      endcase
   end
   // outputs decoded from state; address always tracks pc
   always_comb begin
      imem_req  = state == REQ;
      ins_valid = state == ISSUE;
      halted    = state == HALT;
      imem_addr = pc;
   end
   // INS holds the last issued word until the next non-jump fetch
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) INS <= NOP;
      else if (take && !is_jump) INS <= imem_data;
   pc_counter #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (take && is_jump && !is_halt),
      .inc    (take && !is_jump),
      .target (imem_data[PC_W-1:0]),
      .pc     (pc)
   );
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: directed stimulus with a transaction-level fetch model checked every cycle
module tb_ins_fetch;
   localparam logic [8:0] NOP = 9'b011000000;
   logic clk = 0, rst_n = 0, run = 0, stall = 0, imem_ack = 0;
   logic imem_req, ins_valid, halted;
   logic [7:0] imem_addr, pc;
   logic [8:0] imem_data = '0, INS;
`ifdef INS_FETCH_SINGLE_STEP_EN
   logic step = 0;
`endif
   logic [8:0] mem [256];
   int lat = 0, wcnt = 0;
   logic late_ack = 0;
   int n_chk = 0, n_fail = 0;
   logic hs = 0, rel = 0;
   logic [8:0] hd = '0;
   logic [7:0] m_pc = '0;
   logic [8:0] m_ins = NOP;
   logic m_busy = 0, m_halted = 0;

   always #5 clk = ~clk;

   ins_fetch dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
`ifdef INS_FETCH_SINGLE_STEP_EN
      .step      (step),
`endif
      .imem_addr (imem_addr),
      .imem_req  (imem_req),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .INS       (INS),
      .ins_valid (ins_valid),
      .stall     (stall),
      .pc        (pc),
      .halted    (halted)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = NOP;
      mem[0] = 9'h001; mem[1] = 9'h105; mem[5] = 9'h0C3; mem[6] = 9'h107; mem[7] = 9'h107;
      fork
         forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
               hs <= 0;
               rel <= 0;
            end else begin
               hs <= imem_req & imem_ack;
               hd <= imem_data;
               rel <= ins_valid & ~stall;
            end
         end
         forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
               m_pc = '0; m_ins = NOP; m_busy = 0; m_halted = 0; imem_ack = 0; wcnt = 0;
            end else begin
               if (rel) m_busy = 0;
               if (hs) begin
                  if (hd[8]) begin
                     if (hd[7:0] == m_pc) m_halted = 1;
                     else m_pc = hd[7:0];
                  end else begin
                     m_pc = m_pc + 8'd1;
                     m_ins = hd;
                     m_busy = 1;
                  end
               end
               chk("pc", pc, m_pc);
               chk("INS", INS, m_ins);
               chk("ins_valid", ins_valid, m_busy);
               chk("halted", halted, m_halted);
               if (imem_req) chk("imem_addr", imem_addr, m_pc);
               if (m_halted || m_busy) chk("no_req", imem_req, 0);
               if (late_ack) begin
                  imem_ack = 1; imem_data = 9'h0AA; wcnt = 0;
               end else if (imem_req && wcnt >= lat) begin
                  imem_ack = 1; imem_data = mem[imem_addr]; wcnt = 0;
               end else begin
                  imem_ack = 0; wcnt = imem_req ? wcnt + 1 : 0;
               end
            end
         end
      join_none
      tick(2);
      rst_n = 1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", ins_valid, 0);
      chk("rst_INS", INS, NOP);
      chk("rst_pc", pc, 0);
      chk("rst_halted", halted, 0);
      run = 1;
      tick(1);
      chk("first_req", imem_req, 1);
      chk("first_addr", imem_addr, 0);
      chk("first_valid", ins_valid, 0);
      tick(1);
      chk("issue_valid", ins_valid, 1);
      chk("issue_INS", INS, 9'h001);
      chk("issue_pc", pc, 1);
      chk("issue_noreq", imem_req, 0);
      tick(1);
      chk("req1_addr", imem_addr, 1);
      tick(1);
      chk("jump_req", imem_req, 1);
      chk("jump_addr", imem_addr, 5);
      chk("jump_novalid", ins_valid, 0);
      chk("jump_INS", INS, 9'h001);
      stall = 1;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         chk("stall_valid", ins_valid, 1);
         chk("stall_INS", INS, 9'h0C3);
         chk("stall_noreq", imem_req, 0);
      end
      stall = 0;
      tick(1);
      chk("unstall_valid", ins_valid, 0);
      chk("unstall_addr", imem_addr, 6);
      tick(1);
      chk("jump7_addr", imem_addr, 7);
      tick(1);
      chk("halt_flag", halted, 1);
      chk("halt_pc", pc, 7);
      tick(3);
      chk("halt_noreq", imem_req, 0);
      chk("halt_hold", halted, 1);
      rst_n = 0;
      #1;
      chk("halt_rst_flag", halted, 0);
      chk("halt_rst_pc", pc, 0);
      run = 0;
      tick(1);
      rst_n = 1;
      mem[0] = 9'h1FF; mem[255] = 9'h000;
      run = 1;
      tick(2);
      chk("wrap_addr_ff", imem_addr, 8'hFF);
      tick(1);
      chk("wrap_pc", pc, 0);
      chk("wrap_INS", INS, 9'h000);
      tick(1);
      chk("wrap_next_addr", imem_addr, 0);
      run = 0;
      tick(1);
      chk("jump_idle_req", imem_req, 0);
      chk("jump_idle_pc", pc, 8'hFF);
      tick(2);
      chk("idle_stays", imem_req, 0);
      lat = 4;
      run = 1;
      tick(2);
      chk("wait_req", imem_req, 1);
      rst_n = 0;
      #1;
      chk("async_req_drop", imem_req, 0);
      chk("async_INS", INS, NOP);
      run = 0;
      #1;
      rst_n = 1;
      late_ack = 1;
      for (int k = 0; k < 2; k++) begin
         tick(1);
         chk("late_req", imem_req, 0);
         chk("late_valid", ins_valid, 0);
         chk("late_INS", INS, NOP);
         chk("late_pc", pc, 0);
      end
      late_ack = 0;
      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
